// File: rtl/acq_sampler_pkg.sv
// Shared definitions for the acquisition stage: FSM encoding and default widths
// so the transmit stage and benches agree on buffer geometry.
package acq_sampler_pkg;

  localparam int unsigned CH_WIDTH_DEF   = 8;
  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned PRESCALE_W_DEF = 16;
  localparam int unsigned TIMEOUT_W_DEF  = 24;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } acq_state_e;

endpackage

// File: rtl/acq_sampler_probe_sync.sv
// Two-flop synchroniser bringing the asynchronous probe pins into the clk domain.
module acq_sampler_probe_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/acq_sampler.sv
// Logic-analyser acquisition stage: arm on masked trigger, capture 2**ADDR_W samples.
// Optional ACQ_TIMEOUT_EN adds a force-trigger timeout and the timed_out output.
module acq_sampler
  import acq_sampler_pkg::*;
#(
  parameter int unsigned CH_WIDTH   = CH_WIDTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
`ifdef ACQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_W  = TIMEOUT_W_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant,
  output logic                  done,
  input  logic [CH_WIDTH-1:0]   probe_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CH_WIDTH-1:0]   trig_mask,
  input  logic [CH_WIDTH-1:0]   trig_value,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [CH_WIDTH-1:0]   wr_data,
`ifdef ACQ_TIMEOUT_EN
  output logic                  timed_out,
`endif
  output logic                  busy
);

  acq_state_e            state, state_d;
  logic [PRESCALE_W-1:0] pre_cnt, pre_cnt_d;
  logic [CH_WIDTH-1:0]   sample;
  logic                  wr_en_d, done_d, busy_d;
  logic [ADDR_W-1:0]     wr_addr_d;
  logic [CH_WIDTH-1:0]   wr_data_d;
  logic                  trig_hit, tmo_fire, fire;

  acq_sampler_probe_sync #(.WIDTH(CH_WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (probe_in),
    .q   (sample)
  );

  assign trig_hit = ((sample ^ trig_value) & trig_mask) == '0;

`ifdef ACQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_d;
  logic                 timed_out_d;
  assign tmo_fire = (tmo_cnt == '1);
`else
  assign tmo_fire = 1'b0;
`endif

  // The timeout only stands in for a match; capture is otherwise identical.
  assign fire = trig_hit | tmo_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      pre_cnt   <= pre_cnt_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      done      <= done_d;
      busy      <= busy_d;
`ifdef ACQ_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_d;
      timed_out <= timed_out_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    pre_cnt_d = pre_cnt;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
`ifdef ACQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    timed_out_d = timed_out;
`endif
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_d   = S_ARMED;
          wr_addr_d = '0;
`ifdef ACQ_TIMEOUT_EN
          tmo_cnt_d   = '0;
          timed_out_d = 1'b0;
`endif
        end
      end
      S_ARMED: begin
        // Abort has priority over a coincident match.
        if (!grant) begin
          state_d = S_IDLE;
        end else if (fire) begin
          state_d   = S_CAPTURE;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = sample;
          pre_cnt_d = prescale;
`ifdef ACQ_TIMEOUT_EN
          timed_out_d = !trig_hit;
`endif
        end else begin
`ifdef ACQ_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt + TIMEOUT_W'(1);
`endif
        end
      end
      S_CAPTURE: begin
        // wr_addr only reaches all-ones via the final write, so it marks completion.
        if (!grant) begin
          state_d = S_IDLE;
        end else if (wr_addr == '1) begin
          state_d = S_DONE;
        end else if (pre_cnt == '0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr + ADDR_W'(1);
          wr_data_d = sample;
          pre_cnt_d = prescale;
        end else begin
          pre_cnt_d = pre_cnt - PRESCALE_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!grant) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
  end

endmodule

// File: tb/tb_acq_sampler.sv
// Scoreboard bench for acq_sampler with ADDR_W=4 (16-sample captures).
module tb_acq_sampler;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          grant = 1'b0;
  logic          done;
  logic [CW-1:0] probe_in = '0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] trig_mask = '0;
  logic [CW-1:0] trig_value = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          busy;
`ifdef ACQ_TIMEOUT_EN
  logic          timed_out;
`endif

  acq_sampler #(
    .CH_WIDTH  (CW),
    .ADDR_W    (AW),
    .PRESCALE_W(PW)
`ifdef ACQ_TIMEOUT_EN
    ,
    .TIMEOUT_W (4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .done      (done),
    .probe_in  (probe_in),
    .prescale  (prescale),
    .trig_mask (trig_mask),
    .trig_value(trig_value),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef ACQ_TIMEOUT_EN
    .timed_out (timed_out),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   got_done = 0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.addr = AW'(a);
    e.data = CW'(d);
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every write pops one expected entry; done must follow the last write.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {28'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (done) begin
        got_done++;
        chk("done_after_last_write", 32'(prev_last), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("wr_en_in_done", 32'(wr_en), 32'd0);
      end
      prev_last = wr_en && (wr_addr == '1);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;
    grant = 1'b1;
    // Reset held with grant high and probe toggling: nothing may move.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 probe_in = ~probe_in;
      chk_reset_outputs("reset");
    end
    grant = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(2);

    // Immediate trigger, ramp probe, prescale 0: data lags the pin by 3 edges.
    for (int a = 0; a < 16; a++) push(a, 2 + a);
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk);
      #1 probe_in = CW'(i);
      if (i == 3) grant = 1'b1;
    end
    chk("imm_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("imm_done_count", 32'(got_done), 32'd1);
    grant = 1'b0;

    // Pattern trigger on bit7=1/bit0=0 with prescale 3.
    prescale   = 16'd3;
    trig_mask  = 8'h81;
    trig_value = 8'h80;
    probe_in   = 8'h01;
    cycles(3);
    grant = 1'b1;
    cycles(6);
    chk("armed_busy", 32'(busy), 32'd1);
    for (int a = 0; a < 16; a++) push(a, 8'h80 + 8 * a);
    for (int i = 0; i <= 75; i++) begin
      @(posedge clk);
      #1 probe_in = CW'(8'h80 + 2 * i);
    end
    chk("pat_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pat_done_count", 32'(got_done), 32'd2);
    grant = 1'b0;

    // Abort after five writes, then a full restart from address 0.
    prescale  = '0;
    trig_mask = '0;
    cycles(3);
    for (int a = 0; a < 5; a++) push(a, 2 + a);
    for (int a = 0; a < 16; a++) push(a, 13 + a);
    for (int i = 0; i <= 50; i++) begin
      @(posedge clk);
      #1 probe_in = CW'(i);
      if (i == 3) grant = 1'b1;
      if (i == 9) grant = 1'b0;
      if (i == 14) grant = 1'b1;
      if (i == 11) chk("abort_busy", 32'(busy), 32'd0);
    end
    chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("abort_done_count", 32'(got_done), 32'd3);
    grant = 1'b0;
    cycles(3);

    // Reset mid-capture: two writes seen, then everything clears with no done.
    push(0, 2);
    push(1, 3);
    for (int i = 0; i <= 12; i++) begin
      @(posedge clk);
      #1 probe_in = CW'(i);
      if (i == 3) grant = 1'b1;
      if (i == 7) rst = 1'b0;
    end
    chk_reset_outputs("midrst");
    chk("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("midrst_done_count", 32'(got_done), 32'd3);
    grant = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(3);

`ifdef ACQ_TIMEOUT_EN
    // No match possible: force-trigger once the 4-bit counter saturates.
    trig_mask  = 8'hFF;
    trig_value = 8'hAA;
    for (int a = 0; a < 16; a++) push(a, 17 + a);
    for (int i = 0; i <= 50; i++) begin
      @(posedge clk);
      #1 probe_in = CW'(i);
      if (i == 3) grant = 1'b1;
    end
    chk("tmo_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("tmo_done_count", 32'(got_done), 32'd4);
    chk("tmo_timed_out", 32'(timed_out), 32'd1);
    grant = 1'b0;
    cycles(3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
